// File: rtl/cond_inv_mux_pipe.sv
// cond_inv_mux_pipe
//   Two-stage elastic datapath computing a per-lane conditional-invert / mux
//   function over LANES independent WIDTH-bit lanes.
//   Stage 1 holds the raw beat. The lane function is evaluated from stage 1
//   and captured into stage 2, which drives out_data directly.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     producer handshake
//   in_mode[1:0]          lane function (00 s?~A:B, 01 s?A:B, 10 ~(A&B), 11 s?A^B:B)
//   in_sel[LANES-1:0]     per-lane select
//   in_a/in_b             packed operands, lane i = [i*WIDTH +: WIDTH]
//   out_valid/out_ready   consumer handshake
//   out_data              packed result, stage-2 register
//   txn_cnt               wrapping count of output transfers

module cond_inv_mux_lane #(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       i_mode,
  input  logic             i_sel,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);
  always_comb begin
    o_y = i_b;
    case (i_mode)
      2'b00:   o_y = i_sel ? ~i_a        : i_b;
      2'b01:   o_y = i_sel ?  i_a        : i_b;
      2'b10:   o_y = ~(i_a & i_b);
      default: o_y = i_sel ? (i_a ^ i_b) : i_b;
    endcase
  end
endmodule

module cond_inv_mux_pipe #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_mode,
  input  logic [LANES-1:0]       in_sel,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]       txn_cnt
);
  logic                   r_s1_v;
  logic [1:0]             r_s1_mode;
  logic [LANES-1:0]       r_s1_sel;
  logic [LANES*WIDTH-1:0] r_s1_a;
  logic [LANES*WIDTH-1:0] r_s1_b;
  logic                   r_s2_v;
  logic [LANES*WIDTH-1:0] r_s2_data;
  logic [CNT_W-1:0]       r_cnt;

  logic [LANES*WIDTH-1:0] w_f;
  logic                   w_in_fire;
  logic                   w_out_fire;
  logic                   w_s1_adv;

  // Gated by rst_n so the producer sees no ready while reset is asserted.
  assign in_ready   = rst_n & (~r_s1_v | ~r_s2_v | out_ready);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_s2_v & out_ready;
  assign w_s1_adv   = r_s1_v & (~r_s2_v | out_ready);

  assign out_valid = r_s2_v;
  assign out_data  = r_s2_data;
  assign txn_cnt   = r_cnt;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    cond_inv_mux_lane #(.WIDTH(WIDTH)) u_lane (
      .i_mode (r_s1_mode),
      .i_sel  (r_s1_sel[gi]),
      .i_a    (r_s1_a[gi*WIDTH +: WIDTH]),
      .i_b    (r_s1_b[gi*WIDTH +: WIDTH]),
      .o_y    (w_f[gi*WIDTH +: WIDTH])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v    <= 1'b0;
      r_s1_mode <= '0;
      r_s1_sel  <= '0;
      r_s1_a    <= '0;
      r_s1_b    <= '0;
      r_s2_v    <= 1'b0;
      r_s2_data <= '0;
      r_cnt     <= '0;
    end else begin
      // Operand registers load only on a real accept, so idle-bus garbage
      // never reaches the datapath. in_ready guarantees stage 1 is free or
      // draining whenever a new beat lands.
      if (w_in_fire) begin
        r_s1_v    <= 1'b1;
        r_s1_mode <= in_mode;
        r_s1_sel  <= in_sel;
        r_s1_a    <= in_a;
        r_s1_b    <= in_b;
      end else if (w_s1_adv) begin
        r_s1_v <= 1'b0;
      end

      if (w_s1_adv) begin
        r_s2_v    <= 1'b1;
        r_s2_data <= w_f;
      end else if (w_out_fire) begin
        r_s2_v <= 1'b0;
      end

      if (w_out_fire) r_cnt <= r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_cond_inv_mux_pipe.sv
module tb_cond_inv_mux_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: WIDTH=8, LANES=2, CNT_W=16
  logic        a_iv, a_ir, a_ov, a_or;
  logic [1:0]  a_mode, a_sel;
  logic [15:0] a_a, a_b, a_od, a_cnt;
  // DUT B: WIDTH=1, LANES=1, CNT_W=4
  logic        b_iv, b_ir, b_ov, b_or;
  logic [1:0]  b_mode;
  logic        b_sel, b_a, b_b, b_od;
  logic [3:0]  b_cnt;

  cond_inv_mux_pipe #(.WIDTH(8), .LANES(2), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_mode(a_mode),
    .in_sel(a_sel), .in_a(a_a), .in_b(a_b), .out_valid(a_ov), .out_ready(a_or),
    .out_data(a_od), .txn_cnt(a_cnt));

  cond_inv_mux_pipe #(.WIDTH(1), .LANES(1), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_mode(b_mode),
    .in_sel(b_sel), .in_a(b_a), .in_b(b_b), .out_valid(b_ov), .out_ready(b_or),
    .out_data(b_od), .txn_cnt(b_cnt));

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] fa(input logic [1:0] m, input logic [1:0] s,
                                     input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic [7:0]  x, y, z;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      x = a[i*8 +: 8];
      y = b[i*8 +: 8];
      case (m)
        2'b00:   z = s[i] ? ~x : y;
        2'b01:   z = s[i] ? x : y;
        2'b10:   z = ~(x & y);
        default: z = s[i] ? (x ^ y) : y;
      endcase
      r[i*8 +: 8] = z;
    end
    return r;
  endfunction

  typedef struct { logic s; logic a; logic b; logic exp; } lvec_t;
  typedef struct { logic [1:0] mode; logic [1:0] sel; logic [15:0] a; logic [15:0] b; logic [15:0] exp; } mvec_t;
  lvec_t lv[8];
  mvec_t mv[8];
  logic [15:0] se[100];

  initial begin
    a_iv = 0; a_or = 1; a_mode = 0; a_sel = 0; a_a = 0; a_b = 0;
    b_iv = 0; b_or = 1; b_mode = 0; b_sel = 0; b_a = 0; b_b = 0;

    // legacy truth table: s ? ~a : b
    lv[0] = '{0,0,0,0}; lv[1] = '{0,0,1,1}; lv[2] = '{0,1,0,0}; lv[3] = '{0,1,1,1};
    lv[4] = '{1,0,0,1}; lv[5] = '{1,0,1,1}; lv[6] = '{1,1,0,0}; lv[7] = '{1,1,1,0};
    // a = {0F,A5}, b = {33,3C}; lane1 is the high byte
    mv[0] = '{2'b00, 2'b01, 16'h0FA5, 16'h333C, 16'h335A};
    mv[1] = '{2'b10, 2'b00, 16'h0FA5, 16'h333C, 16'hFCDB};
    mv[2] = '{2'b11, 2'b11, 16'h0FA5, 16'h333C, 16'h3C99};
    mv[3] = '{2'b01, 2'b10, 16'h0FA5, 16'h333C, 16'h0F3C};
    mv[4] = '{2'b00, 2'b10, 16'h0FA5, 16'h333C, 16'hF03C};
    mv[5] = '{2'b11, 2'b01, 16'h0FA5, 16'h333C, 16'h3399};
    mv[6] = '{2'b01, 2'b00, 16'h0FA5, 16'h333C, 16'h333C};
    mv[7] = '{2'b01, 2'b11, 16'h0FA5, 16'h333C, 16'h0FA5};

    // reset state, with edges while held
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_ov", a_ov, 0);  chk("rst_a_od", a_od, 0);
    chk("rst_a_cnt", a_cnt, 0); chk("rst_a_ir", a_ir, 0);
    chk("rst_b_ir", b_ir, 0);  chk("rst_b_ov", b_ov, 0); chk("rst_b_cnt", b_cnt, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("rel_a_ir", a_ir, 1); chk("rel_b_ir", b_ir, 1);
    step();

    // legacy equivalence on the 1-bit instance, 50-cycle spacing
    for (int i = 0; i < 8; i++) begin
      b_sel = lv[i].s; b_a = lv[i].a; b_b = lv[i].b; b_iv = 1;
      step();
      b_iv = 0;
      chk("leg_lat_v", b_ov, 0);
      step();
      chk("leg_v", b_ov, 1);
      chk("leg_d", b_od, lv[i].exp);
      repeat (48) step();
    end
    chk("leg_cnt", b_cnt, 8);

    // mode table on the 2x8 instance
    for (int i = 0; i < 8; i++) begin
      a_mode = mv[i].mode; a_sel = mv[i].sel; a_a = mv[i].a; a_b = mv[i].b; a_iv = 1;
      step();
      a_iv = 0;
      chk("mode_lat_v", a_ov, 0);
      step();
      chk("mode_v", a_ov, 1);
      chk("mode_d", a_od, mv[i].exp);
      repeat (2) step();
    end
    chk("mode_cnt", a_cnt, 8);

    // backpressure: mode 01 sel 11 passes A through
    a_or = 0; a_mode = 2'b01; a_sel = 2'b11; a_b = 16'h0000;
    a_a = 16'h1111; a_iv = 1; #1;
    chk("bp_ir0", a_ir, 1);
    step();
    a_a = 16'h2222; #1;
    chk("bp_ir1", a_ir, 1);
    step();
    a_a = 16'h3333; #1;
    chk("bp_ir2", a_ir, 0);
    step();
    chk("bp_full_ir", a_ir, 0); chk("bp_hold_v", a_ov, 1); chk("bp_hold_d", a_od, 16'h1111);
    step();
    chk("bp_stable_v", a_ov, 1); chk("bp_stable_d", a_od, 16'h1111);
    a_or = 1; #1;
    chk("bp_rel_ir", a_ir, 1); chk("bp_d0", a_od, 16'h1111);
    step();
    a_iv = 0;
    chk("bp_v1", a_ov, 1); chk("bp_d1", a_od, 16'h2222);
    step();
    chk("bp_v2", a_ov, 1); chk("bp_d2", a_od, 16'h3333);
    step();
    chk("bp_empty", a_ov, 0);
    chk("bp_cnt", a_cnt, 11);

    // streaming: 100 random beats back-to-back
    for (int c = 0; c < 103; c++) begin
      if (c >= 2 && c < 102) begin
        chk("str_v", a_ov, 1);
        chk("str_d", a_od, se[c-2]);
      end else begin
        chk("str_idle", a_ov, 0);
      end
      if (c < 100) begin
        a_mode = 2'($urandom_range(0, 3)); a_sel = 2'($urandom);
        a_a = 16'($urandom); a_b = 16'($urandom);
        se[c] = fa(a_mode, a_sel, a_a, a_b);
        a_iv = 1;
      end else begin
        a_iv = 0;
      end
      step();
    end
    chk("str_cnt", a_cnt, 111);

    // counter wrap on the CNT_W=4 instance, starting from 8
    b_mode = 2'b00;
    for (int c = 0; c < 12; c++) begin
      int n;
      n = (c < 2) ? 0 : ((c - 2 > 9) ? 9 : c - 2);
      chk("wrap_cnt", b_cnt, 32'((8 + n) % 16));
      if (c < 9) begin
        b_sel = 1'(c); b_a = 1'(c >> 1); b_b = 1'(c >> 2); b_iv = 1;
      end else begin
        b_iv = 0;
      end
      step();
    end
    chk("wrap_final", b_cnt, 1);

    // reset mid-flight with both stages full
    a_or = 0; a_mode = 2'b01; a_sel = 2'b11;
    a_a = 16'hAAAA; a_iv = 1;
    step();
    a_a = 16'h5555;
    step();
    a_iv = 0;
    chk("mid_full_v", a_ov, 1); chk("mid_full_ir", a_ir, 0);
    #3 rst_n = 0;
    #1;
    chk("mid_rst_v", a_ov, 0); chk("mid_rst_d", a_od, 0);
    chk("mid_rst_cnt", a_cnt, 0); chk("mid_rst_ir", a_ir, 0);
    chk("mid_rst_bcnt", b_cnt, 0);
    @(negedge clk);
    rst_n = 1;
    a_or = 1;
    #1;
    chk("mid_rel_ir", a_ir, 1);
    for (int c = 0; c < 6; c++) begin
      step();
      chk("mid_no_stale", a_ov, 0);
    end
    chk("mid_cnt_after", a_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
